// File: rtl/v60_bus_pkg.sv
// Shared V60 bus definitions: address/data widths, access size encoding and
// the arbiter state encoding used by every bus master on the CPU port.
package v60_bus_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } bus_size_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ISSUE = 2'b01,
    ARB_BUSY  = 2'b10,
    ARB_DONE  = 2'b11
  } arb_state_t;

endpackage

// File: rtl/v60_bus_arbiter.sv
// Arbitrates ifetch and data requesters onto one memory port; request to ack is
// 5 cycles plus memory wait cycles; requesters hold req until ack.
module v60_bus_arbiter
  import v60_bus_pkg::*;
#(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [1:0]            i_size,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic                  d_lock,
  input  logic [1:0]            d_size,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [1:0]            mem_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  bus_owner,
  output logic                  bus_busy
);

  localparam int CW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_DATA_BURST);

  arb_state_t            state;
  logic [CW-1:0]         starve_cnt;
  logic                  lock_flag;
  logic                  owner;
  logic                  lat_wr;
  logic                  lat_lock;
  bus_size_t             lat_size;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  grant_d;
  logic                  grant_i;

  // A locked sequence shuts ifetch out entirely, even past the starvation limit.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == ARB_IDLE && mem_ready) begin
      if (lock_flag) begin
        grant_d = d_req;
      end else if (d_req && !(i_req && starve_cnt == STARVE_MAX)) begin
        grant_d = 1'b1;
      end else begin
        grant_i = i_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      lock_flag  <= 1'b0;
      owner      <= 1'b0;
      lat_wr     <= 1'b0;
      lat_lock   <= 1'b0;
      lat_size   <= SIZE_BYTE;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      mem_req    <= 1'b0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      mem_req <= 1'b0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            owner     <= 1'b1;
            lat_wr    <= d_wr;
            lat_lock  <= d_lock;
            lat_size  <= bus_size_t'(d_size);
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            mem_req   <= 1'b1;
            state     <= ARB_ISSUE;
            if (!i_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + CW'(1);
            end
          end else if (grant_i) begin
            owner      <= 1'b0;
            lat_wr     <= 1'b0;
            lat_lock   <= 1'b0;
            lat_size   <= bus_size_t'(i_size);
            lat_addr   <= i_addr;
            lat_wdata  <= '0;
            mem_req    <= 1'b1;
            state      <= ARB_ISSUE;
            starve_cnt <= '0;
          end
        end
        ARB_ISSUE: begin
          state <= ARB_BUSY;
        end
        ARB_BUSY: begin
          if (mem_ready) begin
            if (owner) begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end else begin
              i_rdata <= mem_rdata;
              i_ack   <= 1'b1;
            end
            state <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          // Lock state follows the lock bit of the data transaction just finished.
          if (owner) begin
            lock_flag <= lat_lock;
          end
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign mem_wr    = lat_wr;
  assign mem_size  = lat_size;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign bus_owner = owner;
  assign bus_busy  = (state != ARB_IDLE);

endmodule

// File: doc/v60_bus_arbiter.md
V60_BUS_ARBITER -- requirements
Module: v60_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_DATA_BURST, default 4: maximum consecutive data grants while an ifetch is pending.
REQ-002 SHALL have ports: clk  in  1  single clock; all state on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 i_req  in  1 / i_size  in  2 / i_addr  in  ADDR_WIDTH: instruction-fetch read request; level, held until i_ack.
REQ-005 i_rdata  out  DATA_WIDTH / i_ack  out  1: fetch read data, valid in the single i_ack cycle.
REQ-006 d_req, d_wr, d_lock  in  1 / d_size  in  2 / d_addr  in  ADDR_WIDTH / d_wdata  in  DATA_WIDTH: data request; d_lock marks an interlocked sequence.
REQ-007 d_rdata  out  DATA_WIDTH / d_ack  out  1: data read result and one-cycle completion.
REQ-008 mem_req, mem_wr  out  1 / mem_size  out  2 / mem_addr  out  ADDR_WIDTH / mem_wdata  out  DATA_WIDTH: request to the memory interface CPU port.
REQ-009 mem_rdata  in  DATA_WIDTH / mem_ready  in  1: memory interface result and ready (high when idle and in its hold cycle).
REQ-010 bus_owner  out  1 (0=ifetch, 1=data) / bus_busy  out  1 (state not IDLE).

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, BUSY, DONE.
REQ-012 IDLE: if any request is pending and mem_ready=1, SHALL select the winner, latch its size/addr/wr/wdata/lock, and go to ISSUE. Otherwise SHALL stay in IDLE.
REQ-013 ISSUE: mem_req=1 for exactly one cycle with the latched fields. Next state BUSY.
REQ-014 BUSY: mem_req=0. When mem_ready=1, SHALL capture mem_rdata into the winner's rdata register and go to DONE. BUSY has no timeout.
REQ-015 DONE: the winner's ack=1 for exactly one cycle. Next state IDLE.
REQ-016 mem_size/mem_addr/mem_wr/mem_wdata SHALL be driven from latched registers and stay stable from ISSUE through DONE.
REQ-017 Requester field changes after the latch, including deassertion of req, SHALL be ignored; the transaction completes and ack still pulses.
REQ-018 Priority: data wins over ifetch, except when starve_cnt==MAX_DATA_BURST, in which case ifetch wins.
REQ-019 starve_cnt SHALL increment on a data grant while i_req=1. It SHALL clear on an ifetch grant, or on a data grant while i_req=0. It SHALL saturate at MAX_DATA_BURST.
REQ-020 Lock: after a data transaction latched with d_lock=1 completes, IDLE SHALL consider only d_req, overriding starvation, until a data transaction latched with d_lock=0 completes.
REQ-021 Zero-wait latency: request sampled in IDLE at cycle T gives ack at T+5; each mem_wait cycle adds 1.
REQ-022 Two back-to-back transactions SHALL be separated by at least one IDLE cycle.
REQ-023 i_ack and d_ack SHALL never both be 1 in the same cycle; mem_req SHALL never be 1 outside ISSUE.

Reset
REQ-024 On rst_n=0 SHALL asynchronously clear: state to IDLE; starve_cnt, lock flag, mem_req, mem_wr, i_ack, d_ack, bus_busy, bus_owner to 0; latched fields and rdata registers to 0.
REQ-025 Reset during ISSUE, BUSY or DONE SHALL abandon the transaction with no ack; the first grant is evaluated in the first IDLE cycle after release.

Structure
REQ-026 Address and data widths SHALL come from the shared V60 defines. Shared package v60_bus_pkg SHALL hold the size encoding (00 byte, 01 halfword, 10 word) and the arbiter state enum.
REQ-027 Single module; no sub-module. The starvation counter and lock flag are inline registers.

Verification
REQ-028 Single data read, mem_wait=0, mem_rdata=32'hDEADBEEF -> one mem_req pulse at T+1, d_ack at T+5 with d_rdata=32'hDEADBEEF, i_ack=0 throughout.
REQ-029 i_req and d_req held continuously, MAX_DATA_BURST=4 -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt is 0 after each I.
REQ-030 d_lock=1 on 3 transactions then d_lock=0 on 1, with i_req held -> no ifetch grant until the 4th data ack; ifetch granted next.
REQ-031 Write d_addr=0x103, d_size=00, d_wdata=0xA5, mem_wait high 3 cycles -> mem_addr/size/wdata stable ISSUE..DONE, d_ack at T+8.
REQ-032 rst_n pulsed low in BUSY -> all outputs 0 immediately, no ack; a new request is granted normally after release.
REQ-033 d_req dropped the cycle after ISSUE -> transaction completes, d_ack pulses once, next IDLE has no stale grant.
